// File: rtl/lsu_subword.sv
// Sub-word load/store unit: converts byte/half/word requests into aligned word
// accesses, with sub-word stores done as a read-modify-write of the target word.
module lsu_subword #(
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;
    logic [31:0] waddr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rbuf_reg;
    logic        err_reg;

    logic        accept;
    logic        req_err;
    logic [31:0] req_waddr;
    logic [31:0] sb_word, sh_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid && (state_reg == IDLE);
    assign req_waddr = {req_addr[31:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            req_err = 1'b1;
        if (req_we && req_funct3[2])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_waddr > LAST_WORD)
            req_err = 1'b1;
    end

    // Per-lane merge of store data into the word read back during RD.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign sb_word[8*gi +: 8] = (off_reg == LANE) ? wdata_reg[7:0]
                                                          : rbuf_reg[8*gi +: 8];
            assign sh_word[8*gi +: 8] = (off_reg[1] == LANE[1]) ? wdata_reg[8*(gi%2) +: 8]
                                                                : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rbuf_reg[{off_reg, 3'b000} +: 8];
    assign half_sel = off_reg[1] ? rbuf_reg[31:16] : rbuf_reg[15:0];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = rbuf_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            off_reg    <= 2'b00;
            waddr_reg  <= 32'h0;
            wdata_reg  <= 32'h0;
            rbuf_reg   <= 32'h0;
            err_reg    <= 1'b0;
        end else begin
            if (accept) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                off_reg    <= req_addr[1:0];
                waddr_reg  <= req_waddr;
                wdata_reg  <= req_wdata;
                err_reg    <= req_err;
            end
            if (state_reg == RD)
                rbuf_reg <= mem_rdata;
        end
    end

    // Memory and response outputs depend only on registered state.
    always_comb begin
        state_next = state_reg;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_we && req_funct3 == 3'b010)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                mem_addr   = waddr_reg;
                state_next = we_reg ? WR : RESP;
            end
            WR: begin
                mem_we   = 1'b1;
                mem_addr = waddr_reg;
                if (funct3_reg[1])      mem_wdata = wdata_reg;
                else if (funct3_reg[0]) mem_wdata = sh_word;
                else                    mem_wdata = sb_word;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_reg;
                resp_rdata = (err_reg || we_reg) ? 32'h0 : load_data;
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a word-wide behavioural data memory.
module tb_lsu_subword;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'h0;
    logic [31:0] poke_data = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_subword #(.DEPTH_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        if (poke_en) mem[poke_idx] <= poke_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after consumption.
    task automatic txn(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input int exp_nwr,
                       input logic [31:0] exp_wa, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat, nwr;
        logic [31:0] wa, wd;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nwr = 0; wa = 32'h0; wd = 32'h0;
        while (!resp_valid && lat < 20) begin
            if (mem_we) begin nwr++; wa = mem_addr; wd = mem_wdata; end
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({name, ".writes"}, 32'(nwr), 32'(exp_nwr));
        chk({name, ".mem_addr"}, wa, exp_wa);
        chk({name, ".mem_wdata"}, wd, exp_wd);
        chk({name, ".rdata"}, resp_rdata, exp_rd);
        chk({name, ".err"}, 32'(resp_err), 32'(exp_err));
        $display("txn %-8s we=%0d f3=%b addr=%h wdata=%h -> lat=%0d writes=%0d rdata=%h err=%0d",
                 name, we, f3, addr, wdata, lat, nwr, resp_rdata, resp_err);
        @(negedge clk);
        chk({name, ".consumed"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        poke_en = 1'b1; poke_idx = idx; poke_data = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int n;
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[3]   <= 32'h11223344;
        mem[4]   <= 32'h8899AABB;
        mem[255] <= 32'hCAFEF00D;

        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        txn("LB",   1'b0, 3'b000, 32'h11, 32'h0, 2, 0, 32'h0, 32'h0, 32'hFFFFFFAA, 1'b0);
        txn("LBU",  1'b0, 3'b100, 32'h11, 32'h0, 2, 0, 32'h0, 32'h0, 32'h000000AA, 1'b0);
        txn("LH",   1'b0, 3'b001, 32'h12, 32'h0, 2, 0, 32'h0, 32'h0, 32'hFFFF8899, 1'b0);
        txn("LHU",  1'b0, 3'b101, 32'h12, 32'h0, 2, 0, 32'h0, 32'h0, 32'h00008899, 1'b0);
        txn("LW",   1'b0, 3'b010, 32'h10, 32'h0, 2, 0, 32'h0, 32'h0, 32'h8899AABB, 1'b0);
        txn("LWtop", 1'b0, 3'b010, 32'h3FC, 32'h0, 2, 0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

        txn("SB",   1'b1, 3'b000, 32'h0D, 32'h12345655, 3, 1, 32'h0C, 32'h11225544, 32'h0, 1'b0);
        txn("LWsb", 1'b0, 3'b010, 32'h0C, 32'h0, 2, 0, 32'h0, 32'h0, 32'h11225544, 1'b0);
        poke(8'd3, 32'h11223344);
        txn("SH",   1'b1, 3'b001, 32'h0E, 32'h0000BEEF, 3, 1, 32'h0C, 32'hBEEF3344, 32'h0, 1'b0);
        txn("SW",   1'b1, 3'b010, 32'h0C, 32'hDEADBEEF, 2, 1, 32'h0C, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("LWsw", 1'b0, 3'b010, 32'h0C, 32'h0, 2, 0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);

        txn("eLWmis", 1'b0, 3'b010, 32'h0E, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1);
        txn("eLHmis", 1'b0, 3'b001, 32'h11, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1);
        txn("eF3",    1'b0, 3'b011, 32'h10, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1);
        txn("eRange", 1'b0, 3'b010, 32'h400, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1);
        txn("eSBU",   1'b1, 3'b100, 32'h10, 32'h55, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Backpressure: response held while a second request stays pending.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        chk("bp.rd_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp.valid0", 32'(resp_valid), 32'd1);
        held = resp_rdata;
        chk("bp.rdata0", held, 32'h8899AABB);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.valid_hold", 32'(resp_valid), 32'd1);
            chk("bp.rdata_hold", resp_rdata, 32'h8899AABB);
            chk("bp.err_hold", 32'(resp_err), 32'd0);
            chk("bp.req_ready_hold", 32'(req_ready), 32'd0);
        end
        $display("txn bp-LW  held 3 cycles rdata=%h", resp_rdata);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp.idle_after", 32'(req_ready), 32'd1);
        chk("bp.valid_after", 32'(resp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp.second_accepted", 32'(req_ready), 32'd0);
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp.second_rdata", resp_rdata, 32'h8899AABB);
        $display("txn bp-LW2 rdata=%h", resp_rdata);
        @(negedge clk);

        // Reset asserted mid-cycle while an SH is in its write cycle.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0E; req_wdata = 32'h00001234;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstwr.mem_we_before", 32'(mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstwr.mem_we", 32'(mem_we), 32'd0);
        chk("rstwr.mem_addr", mem_addr, 32'h0);
        chk("rstwr.mem_wdata", mem_wdata, 32'h0);
        chk("rstwr.req_ready", 32'(req_ready), 32'd1);
        chk("rstwr.resp_valid", 32'(resp_valid), 32'd0);
        $display("txn SH-rst reset during write, mem_we=%0d", mem_we);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr.mem_word", mem[3], 32'hDEADBEEF);
        txn("LWrst", 1'b0, 3'b010, 32'h0C, 32'h0, 2, 0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit placed directly upstream of the byte-addressed data memory. It turns core load/store requests (RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned 32-bit word accesses. Loads are extracted and sign- or zero-extended from the read word. Sub-word stores are executed as a read-modify-write, because the memory always writes four bytes per access.

## Interface
Parameters:
- DEPTH_BYTES, 1024: size of the data memory in bytes. Legal word-aligned addresses are 0..DEPTH_BYTES-4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; only the low byte or halfword is used for SB/SH.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response on an edge where resp_valid && resp_ready.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-funct3 request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned address to memory (low 2 bits always 0).
- mem_wdata  out  32  word written to memory.
- mem_rdata  in  32  combinational memory read data, valid while mem_we=0.

## Operation
States: IDLE, RD, WR, RESP.

On acceptance in IDLE:
- Latch we, funct3, addr and wdata. Set off = addr[1:0] and waddr = {addr[31:2], 2'b00}.
- Raise err if any of the following holds:
  - funct3 is 011, 110 or 111;
  - store with funct3[2]=1;
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - waddr > DEPTH_BYTES-4.
- Next state:
  - err → RESP (no memory access);
  - SW → WR;
  - any load, SB or SH → RD.

State behaviour:
- RD: mem_we=0, mem_addr=waddr. On the edge, capture mem_rdata into rbuf. Loads go to RESP; SB/SH go to WR.
- WR: mem_we=1, mem_addr=waddr, mem_wdata as follows:
  - SW: wdata.
  - SB: rbuf with byte lane off replaced by wdata[7:0].
  - SH: rbuf with halfword lane off[1] replaced by wdata[15:0].
  - Next state is RESP.
- RESP: resp_valid=1. resp_rdata and resp_err stay stable until consumed; on consumption → IDLE.

Load extraction from rbuf (byte lane b = off, halfword lane h = off[1]):
- LB: sign-extend byte b.
- LBU: zero-extend byte b.
- LH: sign-extend halfword h.
- LHU: zero-extend halfword h.
- LW: rbuf unchanged.

Output rules:
- Outside RD/WR: mem_we=0, mem_addr=0, mem_wdata=0.
- mem_* are decoded from registered state only; there is no combinational path from req_* or mem_rdata to mem_*.
- mem_we is high for exactly one cycle per store, never for loads or errors.
- A new request is never accepted while in RD, WR or RESP (req_ready=0).

## Timing
- Reset (rst=0): state → IDLE immediately (asynchronous).
  - Outputs during and after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0. rbuf and latched request are cleared.
  - Reset during WR drops mem_we combinationally before the next edge, so no write occurs.
  - Reset during RD aborts the RMW; the memory word stays unchanged.
- Latency from acceptance edge E0 to first resp_valid cycle (resp_ready held high):
  - Loads and SB/SH: RD after E0, then WR after E1 for stores. resp_valid is high after E1 for loads and after E2 for SB/SH.
  - SW: WR after E0, resp_valid after E1.
  - Error: resp_valid in the cycle after E0.
- Throughput: back-to-back requests are accepted no sooner than the cycle after the response is consumed (IDLE is one cycle).
- resp_ready low: remain in RESP with all outputs frozen, for any number of cycles.
- req_valid may drop without acceptance while req_ready=0; this has no effect.

## Test plan
- Word 0x10 = 0x8899AABB, with resp_ready held high:
  - LB 0x11 → 0xFFFFFFAA;
  - LBU 0x11 → 0x000000AA;
  - LH 0x12 → 0xFFFF8899;
  - LHU 0x12 → 0x00008899;
  - LW 0x10 → 0x8899AABB, resp_valid two cycles after acceptance, mem_we never high.
- Word 0x0C = 0x11223344; SB addr 0x0D, wdata 0x12345655 → one RD cycle, then one WR cycle with mem_addr=0x0C and mem_wdata=0x11225544. Later LW 0x0C → 0x11225544.
- SH addr 0x0E, wdata 0x0000BEEF onto 0x11223344 → write 0xBEEF3344. SW 0x0C, wdata 0xDEADBEEF → no RD cycle; single WR cycle writing 0xDEADBEEF; response one cycle later.
- Error requests:
  - LW 0x0E, LH 0x11, funct3=011 and LW 0x400 each → resp_err=1, resp_rdata=0, mem_we stays 0, resp_valid in the next cycle;
  - SB with funct3=100 → resp_err=1.
- Hold resp_ready=0 for 3 cycles after an LW → resp_valid, resp_rdata and resp_err stable; req_ready=0; a pending req_valid is not accepted until the cycle after consumption.
- Assert rst=0 mid-cycle while in WR of an SH → mem_we falls immediately and all outputs take their reset values. A following LW returns the original word unchanged.
